// File: rtl/rr_arb_mux.sv
// Registered N:1 round-robin multiplexer with valid/ready handshakes on every
// input channel and on the output; accepts at most one word per cycle.
module rr_arb_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SW    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_sel_q, out_sel_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    logic [WIDTH-1:0] ch_data [N];
    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic             gnt_found;
    logic [SW:0]      gnt_off;
    logic [SW:0]      gnt_sum;
    logic [SW-1:0]    gnt_idx;
    logic             load_en;
    logic             xfer;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
        assign in_ready[gi] = xfer && (gnt_idx == SW'(gi));
    end

    // Rotate the request vector so bit 0 is the channel ptr points at; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign req_dbl = {in_valid, in_valid};
    assign req_rot = N'(req_dbl >> ptr_q);

    always_comb begin
        gnt_found = 1'b0;
        gnt_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                gnt_found = 1'b1;
                gnt_off   = (SW+1)'(k);
            end
        end
    end

    assign gnt_sum = {1'b0, ptr_q} + gnt_off;
    assign gnt_idx = (gnt_sum >= (SW+1)'(N)) ? SW'(gnt_sum - (SW+1)'(N)) : SW'(gnt_sum);

    assign load_en = (state_q == EMPTY) || out_ready;
    assign xfer    = load_en && gnt_found && !reset;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_sel_q  <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
            ptr_q      <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        ptr_d      = ptr_q;
        case (state_q)
            EMPTY: if (gnt_found) state_d = FULL;
            FULL:  if (out_ready && !gnt_found) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (xfer) begin
            out_data_d = ch_data[gnt_idx];
            out_sel_d  = gnt_idx;
            // Wrap at N rather than 2^SW so unused codes are never pointed at.
            ptr_d      = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
        end
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == FULL);
        out_data  = out_data_q;
        out_sel   = out_sel_q;
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: expected words are queued as they are granted
// and compared as the consumer takes them from the output register.
`timescale 1ns/1ps
module tb_rr_arb_mux;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SW    = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_sel;
    logic               out_valid;
    logic               out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [SW+WIDTH-1:0] exp_q [$];

    rr_arb_mux #(.WIDTH(WIDTH), .N(N), .SW(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sel, input logic [WIDTH-1:0] data);
        exp_q.push_back({SW'(sel), data});
    endtask

    // Consumer side: every word taken must be the oldest one granted.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'({out_sel, out_data}), 32'hFFFF_FFFF);
            end else begin
                logic [SW+WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("sb_word", 32'({out_sel, out_data}), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_sel",   32'(out_sel),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        reset = 1'b0;

        // Rotation: all channels requesting, grants 0,1,2,3,0,1 with no bubbles.
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            check("rot_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            push(k % 4, WIDTH'(8'h10 + (k % 4)));
            cyc();
            check("rot_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b0;

        // Backpressure: register holds sel 1 / 0x11, nothing accepted.
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_data", 32'(out_data), 32'h11);
            check("bp_out_sel",  32'(out_sel),  32'd1);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'(4'b0100));
        push(2, 8'h12);
        cyc();
        check("bp_next_sel", 32'(out_sel), 32'd2);

        // Wrap/skip: ptr=3 with requests on 3 and 0.
        in_valid = 4'b1001;
        #1;
        check("wrap_grant3", 32'(in_ready), 32'(4'b1000));
        push(3, 8'h13);
        cyc();
        check("wrap_grant0", 32'(in_ready), 32'(4'b0001));
        push(0, 8'h10);
        cyc();

        // ptr=1, only channel 0 requesting -> grant 0, ptr stays 1.
        in_valid = 4'b0001;
        in_data[0 +: WIDTH] = 8'hA5;
        #1;
        check("skip_grant0", 32'(in_ready), 32'(4'b0001));
        push(0, 8'hA5);
        cyc();
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data",  32'(out_data),  32'hA5);
        check("single_out_sel",   32'(out_sel),   32'd0);

        // Drain: no requests, output empties, data/sel hold.
        in_valid = '0;
        #1;
        check("drain_in_ready", 32'(in_ready), 32'd0);
        cyc();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_out_data",  32'(out_data),  32'hA5);
        check("drain_out_sel",   32'(out_sel),   32'd0);

        // ptr must still be 1: channel 1 beats channel 0.
        in_valid = 4'b0011;
        in_data[1*WIDTH +: WIDTH] = 8'h3C;
        #1;
        check("ptr_hold_grant1", 32'(in_ready), 32'(4'b0010));
        push(1, 8'h3C);
        cyc();
        in_valid  = '0;
        out_ready = 1'b0;
        #1;
        check("pre_rst_out_data", 32'(out_data), 32'h3C);

        // Asynchronous reset while FULL: cleared without a clock edge.
        reset    = 1'b1;
        in_valid = 4'b0100;
        in_data[2*WIDTH +: WIDTH] = 8'h77;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data",  32'(out_data),  32'd0);
        check("arst_out_sel",   32'(out_sel),   32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd0);
        exp_q.delete();
        #2;
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'(4'b0100));
        push(2, 8'h77);
        out_ready = 1'b1;
        cyc();
        check("post_rst_sel",   32'(out_sel),   32'd2);
        check("post_rst_data",  32'(out_data),  32'h77);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        in_valid = '0;
        cyc();
        check("final_out_valid", 32'(out_valid), 32'd0);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
